mdriver_axil_bridge: RTL and testbench
======================================

Name: mdriver_axil_bridge

Overview:
Slave-side consumer of the mdriver command interface. Converts one exec/fin four-phase command into a single AXI4-Lite master transaction: a write on AW/W/B or a read on AR/R. Returns read data on so_data and the AXI response code on last_resp. Sits between the testbench/CPU-side command driver and any AXI4-Lite slave register block.

Parameters:
C_AXI_DATA_WIDTH, 32, data width of si_data, so_data, wdata and rdata.
C_AXI_ADDR_WIDTH, 9, byte-address width of si_address, awaddr and araddr.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
si_address  in  C_AXI_ADDR_WIDTH  command byte address
si_data  in  C_AXI_DATA_WIDTH  write data
so_data  out  C_AXI_DATA_WIDTH  last read data
we  in  1  1=write, 0=read
exec  in  1  command request (level)
fin  out  1  command complete (level)
last_resp  out  2  response of the last completed transaction
err  out  1  sticky; set on any non-OKAY response
m_axi_awaddr/awprot/awvalid  out  ADDR/3/1  write address channel
m_axi_awready  in  1
m_axi_wdata/wstrb/wvalid  out  DATA/DATA/8/1  write data channel
m_axi_wready  in  1
m_axi_bresp/bvalid  in  2/1  write response channel; m_axi_bready out 1
m_axi_araddr/arprot/arvalid  out  ADDR/3/1  read address channel
m_axi_arready  in  1
m_axi_rdata/rresp/rvalid  in  DATA/2/1  read data channel; m_axi_rready out 1

Behaviour:
- All outputs are registered. Reset (synchronous, active-high) sets state IDLE and drives every valid/ready, fin, so_data, last_resp and err to 0. Reset mid-transaction abandons the transaction immediately; no valid remains high.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: at an edge with exec=1, latch si_address, si_data and we. Go to WR_REQ (we=1) or RD_REQ (we=0).
- Address: the low log2(DATA_WIDTH/8) bits are forced to 0 (word-aligned). prot=3'b000. wstrb is all ones.
- WR_REQ: awvalid and wvalid go high on entry. Each valid drops on its own handshake. The two handshakes may occur in either order or in the same cycle. Go to WR_RESP after both have completed.
- WR_RESP: bready=1. On bvalid: latch bresp into last_resp, then go to DONE.
- RD_REQ: arvalid=1 until arready, then go to RD_RESP.
- RD_RESP: rready=1. On rvalid: latch rdata into so_data and rresp into last_resp, then go to DONE.
- Writes never modify so_data. so_data holds its value until the next read completes.
- DONE: fin=1 while exec=1. At the first edge with exec=0, set fin=0 and go to IDLE.
  - If exec is already 0 on entry to DONE, fin is high for exactly one cycle.
- exec deasserted during WR_*/RD_* is ignored; the transaction always completes.
- A new command is accepted only in IDLE, so at least one cycle separates fin falling and the next awvalid/arvalid.
- err is set when any completed response is non-OKAY (SLVERR or DECERR). It clears only on reset.
- Latency with a slave that ties ready high and asserts bvalid/rvalid one cycle after the request handshake:
  - exec is sampled at edge E; the request valid is high after E.
  - The handshake occurs at E+1.
  - fin (and so_data on reads) is high after E+2.
- Slave backpressure: a request valid stays asserted with stable payload until its ready is seen; there is no timeout.

Decomposition:
- Package mdriver_pkg holds:
  - the state enum (mdriver_state_t);
  - AXI response constants: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - a function computing the address-alignment mask from the data width.
- No sub-module. A single FSM module binds to the mdriver_int slave modport plus the AXI-Lite ports.

Test Plan:
- Write 0x0A5, 0xDEADBEEF; slave always ready, bvalid one cycle later, OKAY -> awaddr=0x0A4, wdata=0xDEADBEEF, wstrb=4'hF, fin high after E+2, last_resp=0, err=0.
- Read 0x010 with rdata=0x12345678 returned -> so_data=0x12345678 when fin rises; a subsequent write leaves so_data=0x12345678.
- Write where wready comes 3 cycles before awready, then the reverse, then both in the same cycle -> each valid drops exactly on its own handshake; exactly one B handshake per command; fin is raised once.
- Read returning rresp=2'b10 -> last_resp=2'b10, err=1; the next OKAY read leaves err=1 and sets last_resp=0.
- Driver drops exec while the transaction is outstanding -> transaction completes and fin pulses for one cycle. exec held high after fin -> fin stays high until exec falls, then no new request is issued for at least 1 cycle.
- Assert reset while awvalid is high and awready=0 -> next cycle awvalid=0, wvalid=0, fin=0, state IDLE; the next command executes normally.

Source files
------------

// File: rtl/mdriver_pkg.sv
// Shared types and constants for the mdriver command bridge.
// State encoding, AXI response codes and the address alignment helper.
package mdriver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } mdriver_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Clears the byte-lane bits below one data word.
    function automatic logic [31:0] addr_align_mask(input int unsigned data_width);
        return ~((data_width / 8) - 1);
    endfunction

endpackage

// File: rtl/mdriver_if.sv
// Four-phase exec/fin command interface between a driver and a bridge.
// The master issues commands; the slave executes them.
interface mdriver_int #(
    parameter int AW = 9,
    parameter int DW = 32
);

    logic [AW-1:0] si_address;
    logic [DW-1:0] si_data;
    logic [DW-1:0] so_data;
    logic          we;
    logic          exec;
    logic          fin;
    logic [1:0]    last_resp;
    logic          err;

    modport master (
        output si_address, si_data, we, exec,
        input  so_data, fin, last_resp, err
    );

    modport slave (
        input  si_address, si_data, we, exec,
        output so_data, fin, last_resp, err
    );

endinterface

// File: rtl/mdriver_axil_bridge.sv
// Turns one exec/fin command into a single AXI4-Lite read or write.
// Every output comes straight from a register.
module mdriver_axil_bridge
    import mdriver_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    mdriver_int.slave                     cmd,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam logic [AW-1:0] ADDR_MASK = AW'(addr_align_mask(DW));

    mdriver_state_t state, state_n;

    logic [AW-1:0] addr_q, addr_n;
    logic [DW-1:0] wdata_q, wdata_n;
    logic [DW-1:0] so_data_q, so_data_n;
    logic [1:0]    resp_q, resp_n;
    logic          err_q, err_n;
    logic          fin_q, fin_n;
    logic          awvalid_q, awvalid_n;
    logic          wvalid_q, wvalid_n;
    logic          bready_q, bready_n;
    logic          arvalid_q, arvalid_n;
    logic          rready_q, rready_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            so_data_q <= '0;
            resp_q    <= RESP_OKAY;
            err_q     <= 1'b0;
            fin_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state     <= state_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            so_data_q <= so_data_n;
            resp_q    <= resp_n;
            err_q     <= err_n;
            fin_q     <= fin_n;
            awvalid_q <= awvalid_n;
            wvalid_q  <= wvalid_n;
            bready_q  <= bready_n;
            arvalid_q <= arvalid_n;
            rready_q  <= rready_n;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        so_data_n = so_data_q;
        resp_n    = resp_q;
        err_n     = err_q;
        fin_n     = fin_q;
        awvalid_n = awvalid_q;
        wvalid_n  = wvalid_q;
        bready_n  = bready_q;
        arvalid_n = arvalid_q;
        rready_n  = rready_q;
        unique case (state)
            IDLE: begin
                if (cmd.exec) begin
                    addr_n  = cmd.si_address & ADDR_MASK;
                    wdata_n = cmd.si_data;
                    if (cmd.we) begin
                        state_n   = WR_REQ;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end else begin
                        state_n   = RD_REQ;
                        arvalid_n = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently, in any order.
                awvalid_n = awvalid_q && !m_axi_awready;
                wvalid_n  = wvalid_q && !m_axi_wready;
                if (!awvalid_n && !wvalid_n) begin
                    state_n  = WR_RESP;
                    bready_n = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_n = 1'b0;
                    resp_n   = m_axi_bresp;
                    err_n    = err_q | m_axi_bresp[1];
                    fin_n    = 1'b1;
                    state_n  = DONE;
                end
            end
            RD_REQ: begin
                if (m_axi_arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axi_rvalid) begin
                    rready_n  = 1'b0;
                    so_data_n = m_axi_rdata;
                    resp_n    = m_axi_rresp;
                    err_n     = err_q | m_axi_rresp[1];
                    fin_n     = 1'b1;
                    state_n   = DONE;
                end
            end
            DONE: begin
                if (!cmd.exec) begin
                    fin_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

    assign cmd.so_data   = so_data_q;
    assign cmd.fin       = fin_q;
    assign cmd.last_resp = resp_q;
    assign cmd.err       = err_q;

endmodule

// File: tb/tb_mdriver_axil_bridge.sv
// Directed bench for mdriver_axil_bridge with a small AXI4-Lite slave model.
// Slave readiness delays and responses are set per scenario.
module tb_mdriver_axil_bridge;
    import mdriver_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdriver_int #(.AW(AW), .DW(DW)) cmd ();

    logic [AW-1:0]   m_axi_awaddr;
    logic [2:0]      m_axi_awprot;
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wvalid;
    logic            m_axi_wready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid;
    logic            m_axi_bready;
    logic [AW-1:0]   m_axi_araddr;
    logic [2:0]      m_axi_arprot;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [DW-1:0]   m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rvalid;
    logic            m_axi_rready;

    mdriver_axil_bridge #(
        .C_AXI_DATA_WIDTH(DW),
        .C_AXI_ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cmd.slave),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awprot (m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arprot (m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Slave configuration, written only by the stimulus process.
    int          aw_lat = 0;
    int          w_lat = 0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [1:0]  r_resp_cfg = 2'b00;
    logic [DW-1:0] r_data_cfg = '0;

    // Slave state and statistics, written only by the slave process.
    bit aw_fire, w_fire, b_fire, ar_fire, r_fire;
    bit aw_got, w_got, ar_got, fin_prev;
    int aw_wait, w_wait;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int aw_hi, w_hi, fin_rises;
    logic [AW-1:0]   aw_addr_seen, ar_addr_seen;
    logic [DW-1:0]   w_data_seen;
    logic [DW/8-1:0] w_strb_seen;
    logic [2:0]      aw_prot_seen;

    // Handshakes happen at a posedge iff valid&ready are high at the
    // preceding negedge, so the model lives entirely on the negedge.
    always @(negedge clk) begin
        if (reset) begin
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            aw_got = 0; w_got = 0; ar_got = 0; fin_prev = 0;
            aw_wait = 0; w_wait = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
            m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        end else begin
            if (aw_fire) begin aw_got = 1; aw_cnt++; aw_wait = 0; end
            if (w_fire) begin w_got = 1; w_cnt++; w_wait = 0; end
            if (ar_fire) begin ar_got = 1; ar_cnt++; end
            if (b_fire) begin m_axi_bvalid = 0; b_cnt++; end
            if (r_fire) begin m_axi_rvalid = 0; r_cnt++; end
            if (aw_got && w_got && !m_axi_bvalid) begin
                m_axi_bvalid = 1;
                m_axi_bresp = b_resp_cfg;
                aw_got = 0;
                w_got = 0;
            end
            if (ar_got && !m_axi_rvalid) begin
                m_axi_rvalid = 1;
                m_axi_rresp = r_resp_cfg;
                m_axi_rdata = r_data_cfg;
                ar_got = 0;
            end
            if (m_axi_awvalid) begin
                aw_hi++;
                m_axi_awready = (aw_wait >= aw_lat);
                aw_wait++;
            end else m_axi_awready = 0;
            if (m_axi_wvalid) begin
                w_hi++;
                m_axi_wready = (w_wait >= w_lat);
                w_wait++;
            end else m_axi_wready = 0;
            m_axi_arready = m_axi_arvalid;
            aw_fire = m_axi_awvalid && m_axi_awready;
            w_fire = m_axi_wvalid && m_axi_wready;
            ar_fire = m_axi_arvalid && m_axi_arready;
            b_fire = m_axi_bvalid && m_axi_bready;
            r_fire = m_axi_rvalid && m_axi_rready;
            if (aw_fire) begin aw_addr_seen = m_axi_awaddr; aw_prot_seen = m_axi_awprot; end
            if (w_fire) begin w_data_seen = m_axi_wdata; w_strb_seen = m_axi_wstrb; end
            if (ar_fire) ar_addr_seen = m_axi_araddr;
            if (cmd.fin && !fin_prev) fin_rises++;
            fin_prev = cmd.fin;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issues one command, waits for fin, then releases exec for a cycle.
    task automatic run_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic wr, output int lat, output bit ok);
        int c0;
        cmd.si_address = a;
        cmd.si_data = d;
        cmd.we = wr;
        cmd.exec = 1'b1;
        c0 = cyc;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (cmd.fin) begin ok = 1; break; end
        end
        lat = cyc - c0;
        cmd.exec = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_req_valids got=%b want=000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid});
        end
        checks++;
        if ({m_axi_bready, m_axi_rready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_readies got=%b want=00", {m_axi_bready, m_axi_rready});
        end
        checks++;
        if (cmd.fin !== 1'b0) begin
            errors++;
            $display("FAIL reset_fin got=%b want=0", cmd.fin);
        end
        checks++;
        if (cmd.so_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_so_data got=%h want=0", cmd.so_data);
        end
        checks++;
        if (cmd.last_resp !== 2'b00 || cmd.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_err got=%b/%b want=00/0", cmd.last_resp, cmd.err);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d want=%0d", dut.state, IDLE);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int lat;
        bit ok;
        int b0;
        b0 = b_cnt;
        aw_lat = 0; w_lat = 0; b_resp_cfg = RESP_OKAY;
        run_cmd(9'h0A5, 32'hDEADBEEF, 1'b1, lat, ok);
        checks++;
        if (!ok || lat !== 3) begin
            errors++;
            $display("FAIL write_latency got ok=%0d lat=%0d want ok=1 lat=3", ok, lat);
        end
        checks++;
        if (aw_addr_seen !== 9'h0A4 || aw_prot_seen !== 3'b000) begin
            errors++;
            $display("FAIL write_awaddr got=%h/%b want=0a4/000", aw_addr_seen, aw_prot_seen);
        end
        checks++;
        if (w_data_seen !== 32'hDEADBEEF || w_strb_seen !== 4'hF) begin
            errors++;
            $display("FAIL write_wdata got=%h/%h want=deadbeef/f", w_data_seen, w_strb_seen);
        end
        checks++;
        if (cmd.last_resp !== 2'b00 || cmd.err !== 1'b0) begin
            errors++;
            $display("FAIL write_resp got=%b/%b want=00/0", cmd.last_resp, cmd.err);
        end
        checks++;
        if (b_cnt - b0 !== 1 || cmd.fin !== 1'b0) begin
            errors++;
            $display("FAIL write_bcount got=%0d fin=%b want=1 fin=0", b_cnt - b0, cmd.fin);
        end
    endtask

    task automatic test_read();
        int lat;
        bit ok;
        r_data_cfg = 32'h12345678; r_resp_cfg = RESP_OKAY;
        run_cmd(9'h010, 32'h0, 1'b0, lat, ok);
        checks++;
        if (!ok || lat !== 3) begin
            errors++;
            $display("FAIL read_latency got ok=%0d lat=%0d want ok=1 lat=3", ok, lat);
        end
        checks++;
        if (ar_addr_seen !== 9'h010) begin
            errors++;
            $display("FAIL read_araddr got=%h want=010", ar_addr_seen);
        end
        checks++;
        if (cmd.so_data !== 32'h12345678) begin
            errors++;
            $display("FAIL read_so_data got=%h want=12345678", cmd.so_data);
        end
        run_cmd(9'h020, 32'hA5A5A5A5, 1'b1, lat, ok);
        checks++;
        if (!ok || cmd.so_data !== 32'h12345678) begin
            errors++;
            $display("FAIL read_so_data_hold got=%h ok=%0d want=12345678 ok=1", cmd.so_data, ok);
        end
    endtask

    task automatic test_write_order();
        int lat;
        bit ok;
        int a0, w0, ah0, wh0, b0, f0;
        int aw_tab[3] = '{3, 0, 2};
        int w_tab[3] = '{0, 3, 2};
        for (int k = 0; k < 3; k++) begin
            aw_lat = aw_tab[k];
            w_lat = w_tab[k];
            a0 = aw_cnt; w0 = w_cnt; ah0 = aw_hi; wh0 = w_hi; b0 = b_cnt; f0 = fin_rises;
            run_cmd(9'h100 + 9'(k * 4), 32'h1000 + k, 1'b1, lat, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL order%0d_timeout got ok=0 want ok=1", k);
            end
            checks++;
            if (aw_hi - ah0 !== aw_tab[k] + 1) begin
                errors++;
                $display("FAIL order%0d_awvalid_cycles got=%0d want=%0d", k, aw_hi - ah0, aw_tab[k] + 1);
            end
            checks++;
            if (w_hi - wh0 !== w_tab[k] + 1) begin
                errors++;
                $display("FAIL order%0d_wvalid_cycles got=%0d want=%0d", k, w_hi - wh0, w_tab[k] + 1);
            end
            checks++;
            if (aw_cnt - a0 !== 1 || w_cnt - w0 !== 1) begin
                errors++;
                $display("FAIL order%0d_hs_count got=%0d/%0d want=1/1", k, aw_cnt - a0, w_cnt - w0);
            end
            checks++;
            if (b_cnt - b0 !== 1 || fin_rises - f0 !== 1) begin
                errors++;
                $display("FAIL order%0d_b_fin got=%0d/%0d want=1/1", k, b_cnt - b0, fin_rises - f0);
            end
        end
        aw_lat = 0; w_lat = 0;
    endtask

    task automatic test_err();
        int lat;
        bit ok;
        r_data_cfg = 32'h0BAD0BAD; r_resp_cfg = RESP_SLVERR;
        run_cmd(9'h030, 32'h0, 1'b0, lat, ok);
        checks++;
        if (!ok || cmd.last_resp !== 2'b10 || cmd.err !== 1'b1) begin
            errors++;
            $display("FAIL err_slverr got=%b/%b ok=%0d want=10/1 ok=1", cmd.last_resp, cmd.err, ok);
        end
        r_data_cfg = 32'h00C0FFEE; r_resp_cfg = RESP_OKAY;
        run_cmd(9'h034, 32'h0, 1'b0, lat, ok);
        checks++;
        if (!ok || cmd.last_resp !== 2'b00 || cmd.err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got=%b/%b ok=%0d want=00/1 ok=1", cmd.last_resp, cmd.err, ok);
        end
        checks++;
        if (cmd.so_data !== 32'h00C0FFEE) begin
            errors++;
            $display("FAIL err_so_data got=%h want=00c0ffee", cmd.so_data);
        end
    endtask

    task automatic test_exec_handshake();
        int b0, fin_hi, held, lat;
        bit ok;
        b0 = b_cnt;
        fin_hi = 0;
        cmd.si_address = 9'h050; cmd.si_data = 32'h55AA55AA; cmd.we = 1'b1;
        cmd.exec = 1'b1;
        tick();
        cmd.exec = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cmd.fin) fin_hi++;
        end
        checks++;
        if (fin_hi !== 1 || b_cnt - b0 !== 1) begin
            errors++;
            $display("FAIL exec_drop got fin_cycles=%0d b=%0d want=1/1", fin_hi, b_cnt - b0);
        end
        r_data_cfg = 32'hCAFEF00D; r_resp_cfg = RESP_OKAY;
        cmd.si_address = 9'h040; cmd.we = 1'b0;
        cmd.exec = 1'b1;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cmd.fin) begin ok = 1; break; end
        end
        held = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cmd.fin) held++;
        end
        checks++;
        if (!ok || held !== 3 || cmd.so_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL exec_hold got ok=%0d held=%0d data=%h want 1/3/cafef00d", ok, held, cmd.so_data);
        end
        cmd.exec = 1'b0;
        cmd.si_address = 9'h060; cmd.si_data = 32'h600D600D; cmd.we = 1'b1;
        tick();
        checks++;
        if (cmd.fin !== 1'b0 || m_axi_awvalid !== 1'b0) begin
            errors++;
            $display("FAIL exec_gap got fin=%b awvalid=%b want=0/0", cmd.fin, m_axi_awvalid);
        end
        run_cmd(9'h060, 32'h600D600D, 1'b1, lat, ok);
        checks++;
        if (!ok || lat !== 3 || w_data_seen !== 32'h600D600D) begin
            errors++;
            $display("FAIL exec_next got ok=%0d lat=%0d wdata=%h want 1/3/600d600d", ok, lat, w_data_seen);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok;
        aw_lat = 100; w_lat = 0;
        cmd.si_address = 9'h070; cmd.si_data = 32'h77777777; cmd.we = 1'b1;
        cmd.exec = 1'b1;
        tick();
        tick();
        cmd.exec = 1'b0;
        checks++;
        if (m_axi_awvalid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre_awvalid got=%b want=1", m_axi_awvalid);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || cmd.fin !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got aw=%b w=%b fin=%b want=0/0/0",
                     m_axi_awvalid, m_axi_wvalid, cmd.fin);
        end
        checks++;
        if (dut.state !== IDLE || cmd.err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got=%0d err=%b want=%0d/0", dut.state, cmd.err, IDLE);
        end
        reset = 1'b0;
        aw_lat = 0;
        tick();
        run_cmd(9'h1FF, 32'h0F0F0F0F, 1'b1, lat, ok);
        checks++;
        if (!ok || lat !== 3 || aw_addr_seen !== 9'h1FC || w_data_seen !== 32'h0F0F0F0F) begin
            errors++;
            $display("FAIL midrst_next got ok=%0d lat=%0d addr=%h data=%h want 1/3/1fc/0f0f0f0f",
                     ok, lat, aw_addr_seen, w_data_seen);
        end
    endtask

    initial begin
        reset = 1'b1;
        cmd.exec = 1'b0;
        cmd.we = 1'b0;
        cmd.si_address = '0;
        cmd.si_data = '0;
        test_reset();
        test_write();
        test_read();
        test_write_order();
        test_err();
        test_exec_handshake();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
